// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the general-purpose register bank.
// Optional build macro: REGFILE_WRITE_BYPASS_EN (see register_file.sv).
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

    // True when addr names a real entry. NUM_REGS need not be a power of two,
    // so the top of the address space can be out of range.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned num_regs);
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// One register-file entry: enabled register with synchronous clear.
// The declaration initialiser gives the power-up value; clear forces zero.
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int                      DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   INIT       = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] value = INIT;

    // Clear wins over a write in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
        end else if (en) begin
            value <= d;
        end
    end

    assign q = value;

endmodule

// File: rtl/register_file.sv
// General-purpose register bank: NUM_REGS x DATA_WIDTH, one synchronous
// write port, two combinational read ports (A, B), optional hard-wired R0.
// Out-of-range and R0 writes are discarded and flagged on wr_err for one
// cycle; out-of-range reads return 0.
// Optional build macro: REGFILE_WRITE_BYPASS_EN -- when defined, an accepted
// write is forwarded to a read port addressing the same entry in the same
// cycle; otherwise a colliding read returns the old value.
module register_file
    import regfile_pkg::*;
#(
    parameter int                      DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                      NUM_REGS   = DEFAULT_NUM_REGS,
    parameter logic [DATA_WIDTH-1:0]   INIT       = '0,
    parameter int                      ZERO_R0    = 1,
    localparam int                     ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  wr_err
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_ok;
    logic                  wr_bad;
    logic                  wr_err_q = 1'b0;

    // A write is accepted only for an existing entry that is not the
    // hard-wired zero register.
    assign wr_ok  = wr_en && addr_valid(32'(wr_addr), NUM_REGS)
                    && ((ZERO_R0 == 0) || (wr_addr != '0));
    assign wr_bad = wr_en && !wr_ok;

    // Storage: one cell per entry; entry 0 is a constant when R0 is zeroed.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_cell
            regfile_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .INIT       (INIT)
            ) u_cell (
                .clock (clock),
                .clear (clear),
                .en    (wr_ok && (wr_addr == ADDR_WIDTH'(i))),
                .d     (wr_data),
                .q     (regs[i])
            );
        end
    end

    // Error flag: one-cycle pulse after each discarded write, cleared otherwise.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_bad;
        end
    end

    assign wr_err = wr_err_q;

    // Read port A: entry or 0 for out-of-range, optional same-cycle forward.
    always_comb begin
        rd_data_a = '0;
        if (addr_valid(32'(rd_addr_a), NUM_REGS)) begin
            rd_data_a = regs[rd_addr_a];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_ok && !clear && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
`endif
    end

    // Read port B: same structure as port A, fully independent.
    always_comb begin
        rd_data_b = '0;
        if (addr_valid(32'(rd_addr_b), NUM_REGS)) begin
            rd_data_b = regs[rd_addr_b];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_ok && !clear && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file configured as 12 x 32 with R0 zeroed and a
// non-zero power-up value. Directed vector table, then a random run
// against a reference model.
module tb_register_file;
    import regfile_pkg::*;

    localparam int NREGS = 12;
    localparam word_t INIT_VAL = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    word_t      wr_data = '0;
    logic [3:0] rd_addr_a = '0;
    logic [3:0] rd_addr_b = '0;
    word_t      rd_data_a;
    word_t      rd_data_b;
    logic       wr_err;

    always #5 clock = ~clock;

    register_file #(
        .DATA_WIDTH (32),
        .NUM_REGS   (NREGS),
        .INIT       (INIT_VAL),
        .ZERO_R0    (1)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_err    (wr_err)
    );

    // ---------------- scoreboard ----------------
    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    word_t model [16];

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic word_t model_rd(input logic [3:0] a);
        if (a == 4'd0 || a >= 4'(NREGS)) return '0;
        return model[a];
    endfunction

    function automatic logic model_wr_ok(input logic we, input logic [3:0] a);
        return we && (a != 4'd0) && (a < 4'(NREGS));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic clr, input logic we, input logic [3:0] wa,
                         input word_t wd, input logic [3:0] ra, input logic [3:0] rb);
        clear     = clr;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       clr;
        logic       we;
        logic [3:0] wa;
        word_t      wd;
        logic [3:0] ra;
        logic [3:0] rb;
        word_t      exp_a;    // same cycle, before the edge
        word_t      exp_b;
        logic       exp_err;  // after the edge
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    logic       r_we;
    logic [3:0] r_wa;
    logic [3:0] r_ra;
    logic [3:0] r_rb;
    word_t      r_wd;
    word_t      ea;
    word_t      eb;
    logic       eerr;

    initial begin
        // Column order: clr we wa wd ra rb exp_a exp_b exp_err
`ifdef REGFILE_WRITE_BYPASS_EN
        vecs[0]  = '{1'b0, 1'b1, 4'd5,  32'h1234_5678, 4'd5,  4'd6,  32'h1234_5678, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd3,  32'hAAAA_0001, 4'd3,  4'd5,  32'hAAAA_0001, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd11, 32'h0BAD_F00D, 4'd11, 4'd12, 32'h0BAD_F00D, 32'h0, 1'b0};
`else
        vecs[0]  = '{1'b0, 1'b1, 4'd5,  32'h1234_5678, 4'd5,  4'd6,  32'h0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd3,  32'hAAAA_0001, 4'd3,  4'd5,  32'h0000_0007, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd11, 32'h0BAD_F00D, 4'd11, 4'd12, 32'h0, 32'h0, 1'b0};
`endif
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd5,  4'd5,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd3,  32'h0000_0007, 4'd5,  4'd6,  32'h1234_5678, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd3,  4'd3,  32'hAAAA_0001, 32'hAAAA_0001, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd0,  32'hFFFF_FFFF, 4'd0,  4'd3,  32'h0, 32'hAAAA_0001, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd0,  4'd0,  32'h0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'd13, 32'h5555_5555, 4'd13, 4'd11, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd13, 4'd5,  32'h0, 32'h1234_5678, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd12, 32'h7777_7777, 4'd11, 4'd12, 32'h0BAD_F00D, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 4'd2,  32'h2222_2222, 4'd2,  4'd11, 32'h0, 32'h0BAD_F00D, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd2,  4'd11, 32'h0, 32'h0, 1'b0};

        // Power-up: entries hold INIT, R0 and out-of-range still read 0.
        drive(1'b0, 1'b0, 4'd0, '0, 4'd5, 4'd0);
        check("powerup_a_entry5", rd_data_a, INIT_VAL);
        check("powerup_b_r0", rd_data_b, 32'h0);
        check("powerup_wr_err", {31'b0, wr_err}, 32'h0);
        drive(1'b0, 1'b0, 4'd0, '0, 4'd13, 4'd11);
        check("powerup_a_oor", rd_data_a, 32'h0);
        check("powerup_b_entry11", rd_data_b, INIT_VAL);

        // Reset: one edge of clear; every address reads 0 on both ports.
        drive(1'b1, 1'b0, 4'd0, '0, 4'd0, 4'd0);
        step();
        drive(1'b0, 1'b0, 4'd0, '0, 4'd0, 4'd0);
        check("reset_wr_err", {31'b0, wr_err}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, '0, 4'(i), 4'(15 - i));
            check($sformatf("reset_a_addr%0d", i), rd_data_a, 32'h0);
            check($sformatf("reset_b_addr%0d", 15 - i), rd_data_b, 32'h0);
        end

        // Directed table.
        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].clr, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb);
            check($sformatf("vec%0d_rd_a", v), rd_data_a, vecs[v].exp_a);
            check($sformatf("vec%0d_rd_b", v), rd_data_b, vecs[v].exp_b);
            step();
            check($sformatf("vec%0d_wr_err", v), {31'b0, wr_err}, {31'b0, vecs[v].exp_err});
        end

        // Back-to-back discarded writes then clear: pulse held while errors
        // continue, then clear overrides a bad write on the same edge.
        drive(1'b0, 1'b1, 4'd14, 32'h1, 4'd0, 4'd0);
        step();
        check("seq_err_first", {31'b0, wr_err}, 32'h1);
        drive(1'b0, 1'b1, 4'd0, 32'h2, 4'd0, 4'd0);
        step();
        check("seq_err_second", {31'b0, wr_err}, 32'h1);
        drive(1'b1, 1'b1, 4'd15, 32'h3, 4'd0, 4'd0);
        step();
        check("seq_err_cleared", {31'b0, wr_err}, 32'h0);
        drive(1'b0, 1'b0, 4'd0, '0, 4'd0, 4'd0);

        // Random run against the model; state is all-zero here.
        for (int i = 0; i < 16; i++) model[i] = '0;
        for (int c = 0; c < 2000; c++) begin
            r_we = 1'($urandom_range(0, 1));
            r_wa = 4'($urandom_range(0, 15));
            r_wd = $urandom;
            r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, 15));
            r_rb = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, 15));
            ea = model_rd(r_ra);
            eb = model_rd(r_rb);
`ifdef REGFILE_WRITE_BYPASS_EN
            if (model_wr_ok(r_we, r_wa) && r_ra == r_wa) ea = r_wd;
            if (model_wr_ok(r_we, r_wa) && r_rb == r_wa) eb = r_wd;
`endif
            eerr = r_we && !model_wr_ok(r_we, r_wa);
            exp_q.push_back(ea);
            exp_q.push_back(eb);
            exp_q.push_back({31'b0, eerr});
            drive(1'b0, r_we, r_wa, r_wd, r_ra, r_rb);
            check("rand_rd_a", rd_data_a, exp_q.pop_front());
            check("rand_rd_b", rd_data_b, exp_q.pop_front());
            step();
            check("rand_wr_err", {31'b0, wr_err}, exp_q.pop_front());
            if (model_wr_ok(r_we, r_wa)) model[r_wa] = r_wd;
        end

        // Final sweep: every entry on both ports matches the model.
        drive(1'b0, 1'b0, 4'd0, '0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, '0, 4'(i), 4'(i));
            check($sformatf("sweep_a_addr%0d", i), rd_data_a, model_rd(4'(i)));
            check($sformatf("sweep_b_addr%0d", i), rd_data_b, model_rd(4'(i)));
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
